// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
//  - opcode encodings (IR[31:27])
//  - sequencer state encoding (T0..T6, HALT)
//  - IR field positions
//  - strobe bundle type and opcode classification helper
package cpu_ctrl_pkg;

   localparam int WORD_W = 32;
   localparam int OPC_W  = 5;

   // IR field positions
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;

   localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OPC_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OPC_SHR  = 5'b01001;
   localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01010;
   localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01011;
   localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01100;
   localparam logic [OPC_W-1:0] OPC_ANDI = 5'b01101;
   localparam logic [OPC_W-1:0] OPC_ORI  = 5'b01110;
   localparam logic [OPC_W-1:0] OPC_DIV  = 5'b01111;
   localparam logic [OPC_W-1:0] OPC_MUL  = 5'b10000;
   localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
   localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
   localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
   localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

   typedef enum logic [2:0] {
      T0, T1, T2, T3, T4, T5, T6, HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU, CLS_IMM, CLS_NEGNOT, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
   } opc_class_t;

   typedef struct packed {
      logic PCout;
      logic MDRout;
      logic Zhighout;
      logic Zlowout;
      logic Cout;
      logic PCin;
      logic MARin;
      logic MDRin;
      logic IRin;
      logic Yin;
      logic HIin;
      logic LOin;
      logic ZHighIn;
      logic ZLowIn;
      logic IncPC;
      logic Read;
      logic Gra;
      logic Grb;
      logic Grc;
      logic Rin;
      logic Rout;
   } strobes_t;

   function automatic opc_class_t classify(input logic [OPC_W-1:0] opc);
      opc_class_t cls;
      case (opc)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR, OPC_ROL,
         OPC_SHR, OPC_SHRA, OPC_SHL:    cls = CLS_ALU;
         OPC_ADDI, OPC_ANDI, OPC_ORI:   cls = CLS_IMM;
         OPC_NEG, OPC_NOT:              cls = CLS_NEGNOT;
         OPC_MUL, OPC_DIV:              cls = CLS_MULDIV;
         OPC_NOP:                       cls = CLS_NOP;
         OPC_HALT:                      cls = CLS_HALT;
         default:                       cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ctrl_state_decode.sv
// Pure combinational decode of sequencer state + latched opcode into the
// DataPath strobe bundle.
//  state   in  sequencer state
//  opc     in  opcode latched at T3 entry
//  strobes out DataPath control strobes
//  opcode  out ALU operation (non-zero only in T4)
//  run     out 0 only in HALT
//  illegal out 1 in T3 of an unsupported opcode
module ctrl_state_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t           state,
   input  logic [OPC_W-1:0] opc,
   output strobes_t         strobes,
   output logic [OPC_W-1:0] opcode,
   output logic             run,
   output logic             illegal
);

   opc_class_t cls;

   always_comb begin
      strobes = '0;
      opcode  = '0;
      run     = 1'b1;
      illegal = 1'b0;
      cls     = classify(opc);
      case (state)
         T0: begin
            strobes.PCout = 1'b1;
            strobes.MARin = 1'b1;
            strobes.IncPC = 1'b1;
         end
         T1: begin
            strobes.Read  = 1'b1;
            strobes.MDRin = 1'b1;
         end
         T2: begin
            strobes.MDRout = 1'b1;
            strobes.IRin   = 1'b1;
         end
         T3: begin
            case (cls)
               CLS_ALU, CLS_IMM, CLS_NEGNOT: begin
                  strobes.Grb  = 1'b1;
                  strobes.Rout = 1'b1;
                  strobes.Yin  = 1'b1;
               end
               CLS_MULDIV: begin
                  strobes.Gra  = 1'b1;
                  strobes.Rout = 1'b1;
                  strobes.Yin  = 1'b1;
               end
               CLS_ILLEGAL: illegal = 1'b1;
               default: ;
            endcase
         end
         T4: begin
            opcode = opc;
            strobes.ZLowIn = 1'b1;
            case (cls)
               CLS_ALU: begin
                  strobes.Grc  = 1'b1;
                  strobes.Rout = 1'b1;
               end
               CLS_IMM: strobes.Cout = 1'b1;
               CLS_MULDIV: begin
                  strobes.Grb     = 1'b1;
                  strobes.Rout    = 1'b1;
                  strobes.ZHighIn = 1'b1;
               end
               default: ;
            endcase
         end
         T5: begin
            strobes.Zlowout = 1'b1;
            if (cls == CLS_MULDIV) begin
               strobes.LOin = 1'b1;
            end else begin
               strobes.Gra = 1'b1;
               strobes.Rin = 1'b1;
            end
         end
         T6: begin
            strobes.Zhighout = 1'b1;
            strobes.HIin     = 1'b1;
         end
         HALT: run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer for the DataPath.
//  clock    in  system clock (rising edge)
//  clear    in  asynchronous active-low reset
//  ir       in  instruction register contents
//  mem_rdy  in  memory read complete (holds T1 while 0)
//  PCout..Rout  out  DataPath bus-drive / load / select strobes
//  opcode   out ALU operation, IR opcode during T4 only
//  Run      out 0 once halted
//  illegal  out pulse in T3 of an unsupported opcode
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int WORD_W = cpu_ctrl_pkg::WORD_W,
   parameter int OPC_W  = cpu_ctrl_pkg::OPC_W
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [WORD_W-1:0] ir,
   input  logic              mem_rdy,
   output logic              PCout,
   output logic              MDRout,
   output logic              Zhighout,
   output logic              Zlowout,
   output logic              Cout,
   output logic              PCin,
   output logic              MARin,
   output logic              MDRin,
   output logic              IRin,
   output logic              Yin,
   output logic              HIin,
   output logic              LOin,
   output logic              ZHighIn,
   output logic              ZLowIn,
   output logic              IncPC,
   output logic              Read,
   output logic              Gra,
   output logic              Grb,
   output logic              Grc,
   output logic              Rin,
   output logic              Rout,
   output logic [OPC_W-1:0]  opcode,
   output logic              Run,
   output logic              illegal
);

   state_t           state, state_next;
   logic [OPC_W-1:0] opc_q;
   opc_class_t       cls;
   strobes_t         dec_strobes, s;
   logic [OPC_W-1:0] dec_opcode;
   logic             dec_run, dec_illegal;
   logic             unused_ir_bits;

   assign unused_ir_bits = ^ir[OPC_LO-1:0];
   assign cls = classify(opc_q);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= T0;
      else        state <= state_next;
   end

   // Opcode is captured on the T2->T3 edge so later IR changes cannot disturb execute.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)            opc_q <= '0;
      else if (state == T2)  opc_q <= ir[OPC_HI:OPC_LO];
   end

   always_comb begin
      state_next = state;
      case (state)
         T0: state_next = T1;
         T1: state_next = mem_rdy ? T2 : T1;
         T2: state_next = T3;
         T3: begin
            case (cls)
               CLS_NOP, CLS_ILLEGAL: state_next = T0;
               CLS_HALT:             state_next = HALT;
               default:              state_next = T4;
            endcase
         end
         T4: state_next = T5;
         T5: state_next = (cls == CLS_MULDIV) ? T6 : T0;
         T6: state_next = T0;
         HALT: state_next = HALT;
         default: state_next = T0;
      endcase
   end

   ctrl_state_decode u_decode (
      .state   (state),
      .opc     (opc_q),
      .strobes (dec_strobes),
      .opcode  (dec_opcode),
      .run     (dec_run),
      .illegal (dec_illegal)
   );

   // State already reads T0 during reset, but T0 decodes fetch strobes; the
   // asynchronous gate keeps every strobe quiet while clear is held low.
   assign s       = clear ? dec_strobes : '0;
   assign opcode  = clear ? dec_opcode : '0;
   assign illegal = clear & dec_illegal;
   assign Run     = dec_run | ~clear;

   assign PCout    = s.PCout;
   assign MDRout   = s.MDRout;
   assign Zhighout = s.Zhighout;
   assign Zlowout  = s.Zlowout;
   assign Cout     = s.Cout;
   assign PCin     = s.PCin;
   assign MARin    = s.MARin;
   assign MDRin    = s.MDRin;
   assign IRin     = s.IRin;
   assign Yin      = s.Yin;
   assign HIin     = s.HIin;
   assign LOin     = s.LOin;
   assign ZHighIn  = s.ZHighIn;
   assign ZLowIn   = s.ZLowIn;
   assign IncPC    = s.IncPC;
   assign Read     = s.Read;
   assign Gra      = s.Gra;
   assign Grb      = s.Grb;
   assign Grc      = s.Grc;
   assign Rin      = s.Rin;
   assign Rout     = s.Rout;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process pushes the expected
// per-cycle output vector; a negedge monitor pops and compares, and also checks
// that at most one bus source is driven.
module tb_control_unit;

   typedef logic [27:0] vec_t;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] ir = '0;
   logic        mem_rdy = 1'b1;
   logic PCout, MDRout, Zhighout, Zlowout, Cout, PCin, MARin, MDRin, IRin, Yin;
   logic HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
   logic [4:0] opcode;
   logic Run, illegal;

   int checks = 0;
   int errors = 0;
   vec_t  exp_q[$];
   string tag_q[$];

   control_unit #(.WORD_W(32), .OPC_W(5)) dut (
      .clock(clock), .clear(clear), .ir(ir), .mem_rdy(mem_rdy),
      .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .Cout(Cout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
      .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
      .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
      .Rout(Rout), .opcode(opcode), .Run(Run), .illegal(illegal)
   );

   always #5 clock = ~clock;

   vec_t act;
   assign act = {PCout, MDRout, Zhighout, Zlowout, Cout, PCin, MARin, MDRin,
                 IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read,
                 Gra, Grb, Grc, Rin, Rout, opcode, Run, illegal};

   localparam vec_t M_PCOUT    = vec_t'(1) << 27;
   localparam vec_t M_MDROUT   = vec_t'(1) << 26;
   localparam vec_t M_ZHIGHOUT = vec_t'(1) << 25;
   localparam vec_t M_ZLOWOUT  = vec_t'(1) << 24;
   localparam vec_t M_COUT     = vec_t'(1) << 23;
   localparam vec_t M_MARIN    = vec_t'(1) << 21;
   localparam vec_t M_MDRIN    = vec_t'(1) << 20;
   localparam vec_t M_IRIN     = vec_t'(1) << 19;
   localparam vec_t M_YIN      = vec_t'(1) << 18;
   localparam vec_t M_HIIN     = vec_t'(1) << 17;
   localparam vec_t M_LOIN     = vec_t'(1) << 16;
   localparam vec_t M_ZHIGHIN  = vec_t'(1) << 15;
   localparam vec_t M_ZLOWIN   = vec_t'(1) << 14;
   localparam vec_t M_INCPC    = vec_t'(1) << 13;
   localparam vec_t M_READ     = vec_t'(1) << 12;
   localparam vec_t M_GRA      = vec_t'(1) << 11;
   localparam vec_t M_GRB      = vec_t'(1) << 10;
   localparam vec_t M_GRC      = vec_t'(1) << 9;
   localparam vec_t M_RIN      = vec_t'(1) << 8;
   localparam vec_t M_ROUT     = vec_t'(1) << 7;
   localparam vec_t M_RUN      = vec_t'(1) << 1;
   localparam vec_t M_ILL      = vec_t'(1) << 0;
   localparam vec_t M_BUS = M_PCOUT | M_MDROUT | M_ZHIGHOUT | M_ZLOWOUT | M_COUT | M_ROUT;

   localparam vec_t E_RST   = M_RUN;
   localparam vec_t E_T0    = M_PCOUT | M_MARIN | M_INCPC | M_RUN;
   localparam vec_t E_T1    = M_READ | M_MDRIN | M_RUN;
   localparam vec_t E_T2    = M_MDROUT | M_IRIN | M_RUN;
   localparam vec_t E_T3RB  = M_GRB | M_ROUT | M_YIN | M_RUN;
   localparam vec_t E_T3RA  = M_GRA | M_ROUT | M_YIN | M_RUN;
   localparam vec_t E_T5    = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
   localparam vec_t E_T5MD  = M_ZLOWOUT | M_LOIN | M_RUN;
   localparam vec_t E_T6MD  = M_ZHIGHOUT | M_HIIN | M_RUN;
   localparam vec_t E_HALT  = '0;
   localparam vec_t E_ILL   = M_ILL | M_RUN;

   function automatic vec_t op_bits(input logic [4:0] op);
      return {21'b0, op, 2'b0};
   endfunction

   task automatic chk(input string tag, input vec_t a, input vec_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", tag, a, e);
      end
   endtask

   // Monitor: every cycle sampled at the negative edge
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         chk(tag_q.pop_front(), act, exp_q.pop_front());
      end
      checks++;
      if ($countones(act & M_BUS) > 1) begin
         errors++;
         $display("FAIL bus_onehot actual=%h expected_at_most_one_of=%h", act & M_BUS, M_BUS);
      end
   end

   task automatic cyc(input vec_t e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input logic [31:0] irv, input int waits);
      ir = irv;
      mem_rdy = 1'b1;
      cyc(E_T0, "T0");
      for (int i = 0; i <= waits; i++) begin
         mem_rdy = (i == waits);
         cyc(E_T1, "T1");
      end
      mem_rdy = 1'b1;
      cyc(E_T2, "T2");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      @(posedge clock); #1;
      cyc(E_RST, "reset");
      cyc(E_RST, "reset");
      clear = 1'b1;

      // add R1,R2,R3; IR scrambled after T3 entry must not affect opcode
      fetch(32'h18918000, 0);
      cyc(E_T3RB, "add T3");
      ir = 32'hFFFFFFFF;
      cyc(M_GRC | M_ROUT | M_ZLOWIN | M_RUN | op_bits(5'b00011), "add T4");
      cyc(E_T5, "add T5");

      // neg
      fetch(32'h8A1B8000, 0);
      cyc(E_T3RB, "neg T3");
      cyc(M_ZLOWIN | M_RUN | op_bits(5'b10001), "neg T4");
      cyc(E_T5, "neg T5");

      // mul
      fetch(32'h81180000, 0);
      cyc(E_T3RA, "mul T3");
      cyc(M_GRB | M_ROUT | M_ZHIGHIN | M_ZLOWIN | M_RUN | op_bits(5'b10000), "mul T4");
      cyc(E_T5MD, "mul T5");
      cyc(E_T6MD, "mul T6");

      // ori (immediate)
      fetch(32'h70000000, 0);
      cyc(E_T3RB, "ori T3");
      cyc(M_COUT | M_ZLOWIN | M_RUN | op_bits(5'b01110), "ori T4");
      cyc(E_T5, "ori T5");

      // div
      fetch(32'h78000000, 0);
      cyc(E_T3RA, "div T3");
      cyc(M_GRB | M_ROUT | M_ZHIGHIN | M_ZLOWIN | M_RUN | op_bits(5'b01111), "div T4");
      cyc(E_T5MD, "div T5");
      cyc(E_T6MD, "div T6");

      // memory wait: 3 extra T1 cycles
      fetch(32'h20918000, 3);
      cyc(E_T3RB, "sub T3");
      cyc(M_GRC | M_ROUT | M_ZLOWIN | M_RUN | op_bits(5'b00100), "sub T4");
      cyc(E_T5, "sub T5");

      // unsupported opcode, then nop
      fetch(32'hF8000000, 0);
      cyc(E_ILL, "illegal T3");
      fetch(32'hD0000000, 0);
      cyc(E_RST, "nop T3");

      // asynchronous reset in the middle of T4
      fetch(32'h18918000, 0);
      cyc(E_T3RB, "add2 T3");
      exp_q.push_back(M_GRC | M_ROUT | M_ZLOWIN | M_RUN | op_bits(5'b00011));
      tag_q.push_back("add2 T4");
      @(negedge clock); #1;
      clear = 1'b0;
      #1;
      chk("async_reset", act, E_RST);
      @(posedge clock); #1;
      cyc(E_RST, "reset hold");
      clear = 1'b1;

      // halt: no fetch ever resumes, whatever the inputs do
      fetch(32'hD8000000, 0);
      cyc(E_RST, "halt T3");
      for (int i = 0; i < 20; i++) begin
         ir = 32'h18918000;
         mem_rdy = i[0];
         cyc(E_HALT, "halted");
      end
      clear = 1'b0;
      cyc(E_RST, "reset after halt");
      clear = 1'b1;
      mem_rdy = 1'b1;
      cyc(E_T0, "T0 after halt");
      cyc(E_T1, "T1 after halt");

      @(negedge clock); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
